mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter that lets the fetch path (IF1) and the data-access path (MEM) share one synchronous-read unified RAM. Grants at most one access per cycle, routes the one-cycle-later read data to the winning requester, and protects fetch from starvation behind back-to-back loads and stores. Honours the pipeline `cancel` so that flushed fetch responses never reach IF2.

## Interface
Parameters:
- `ADDR_W`, 8: RAM word-address width; RAM address is `addr[ADDR_W+1:2]`.
- `STARVE_MAX`, 4: consecutive denied IF cycles after which IF gets one forced grant; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `cancel`  in  1  pipeline cancel from WB; kills fetch traffic.
- `if_req`  in  1  fetch request.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  32  fetch data.
- `dm_req`  in  1  data request.
- `dm_wen`  in  4  byte write enables; 0 means load.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  store data.
- `dm_gnt`  out  1  data access accepted this cycle.
- `dm_rvalid`  out  1  load data valid.
- `dm_rdata`  out  32  load data.
- `ram_en`  out  1  RAM enable.
- `ram_wen`  out  4  RAM byte write enables.
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid the cycle after `ram_en`.
- `stat_if_stall`  out  32  cycles IF was denied.
- `stat_dm_gnt`  out  32  data grants issued.

## Operation
- Grants are combinational in the request cycle. `ram_en`, `ram_wen`, `ram_addr` and `ram_wdata` are driven from the winner in the same cycle.
- Priority: DM beats IF by default. When the starve counter equals `STARVE_MAX` and `if_req` is high, IF wins and DM is denied for that cycle.
- Starve counter (4-bit):
  - increments each cycle that `if_req & ~if_gnt`, saturating at `STARVE_MAX`;
  - cleared on `if_gnt`, or on any cycle with `if_req` low.
- Response FSM records the owner of the access issued in cycle N. States:
  - RESP_NONE: nothing issued, a store, or a cancelled fetch.
  - RESP_IF: a fetch was granted without cancel.
  - RESP_DM: a load was granted.
- The FSM moves to its next state every cycle, with no hold.
- Outputs in cycle N+1:
  - RESP_IF: `if_rvalid=1`, gated by `~cancel` in N+1.
  - RESP_DM: `dm_rvalid=1`.
- `if_rdata` and `dm_rdata` both carry `ram_rdata` directly. They are meaningful only while the matching rvalid is high, and the requester captures them that cycle.
- Stores (`dm_wen!=0`) get `dm_gnt` and never produce `dm_rvalid`.
- `cancel`:
  - in cycle N forces `if_gnt=0` in N;
  - suppresses `if_rvalid` in N;
  - clears the starve counter.
- DM traffic is unaffected by `cancel`.
- Address bits `[1:0]` and above `ADDR_W+1` are ignored, so accesses alias.
- When there is no request, `ram_en=0`, `ram_wen=0`, and the address and data hold their last value.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in RESP_NONE;
  - starve counter 0;
  - stats 0.
- While `resetn=0`, no grants are issued.
- Reset asserted mid-operation drops any pending response: no rvalid is produced in the cycle after reset.
- Read latency is exactly 1 cycle from grant to rvalid.
- Throughput is one access per cycle, with no bubble between owners.
- Simultaneous events:
  - `if_req` and `dm_req` together with counter below `STARVE_MAX`: DM wins.
  - Counter at `STARVE_MAX`: IF wins.
  - `cancel` together with a forced-IF cycle: nobody is granted IF; DM is granted if requesting, and the counter clears.
- A requester keeps `req`/`addr`/`wdata` stable until it sees `gnt`.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - `stat_if_stall` increments on every `if_req & ~if_gnt` cycle.
  - `stat_dm_gnt` increments on every `dm_gnt`.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both stat ports are tied to 0 and no counter flops exist.

## Structure
- The shared package `pipeline_pkg` holds:
  - the response-owner enum (RESP_NONE, RESP_IF, RESP_DM);
  - the `ADDR_W` default;
  - the `STARVE_MAX` default.
- Sub-module `arb_starve_cnt` is the saturating starve counter. It takes increment, clear and max inputs and outputs `at_max`.

## Test plan
- Reset then lone fetch: `if_req=1`, `if_addr=0x10` -> `if_gnt=1`, `ram_addr=4`, and next cycle `if_rvalid=1` with `if_rdata` = RAM word 4.
- Load/fetch collision: both requesting, `dm_addr=0x20` load -> `dm_gnt=1`, `if_gnt=0`, next cycle `dm_rvalid=1`, `if_rvalid=0`.
- Starvation with `STARVE_MAX=4`: DM requests every cycle and IF requests continuously -> DM granted on cycles 0–3, IF on cycle 4, DM again from cycle 5.
- Cancel: fetch granted at N, `cancel=1` at N+1 -> `if_rvalid=0` at N+1, `if_gnt=0` at N+1, and the starve counter reads 0.
- Store: `dm_wen=4'b0011`, `dm_addr=0x8`, `dm_wdata=0xAABBCCDD` -> `ram_wen=0011`, no `dm_rvalid`; a subsequent load of 0x8 returns the low halfword `0xCCDD` merged into the old word.
- Stats (with `MEM_ARB_STATS_EN`): after the starvation test, `stat_if_stall=4` and `stat_dm_gnt=4`. Without the macro, both read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: response-owner encoding and arbiter defaults.
package pipeline_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_DM   = 2'd2
    } resp_owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch path was denied the RAM.
module arb_starve_cnt (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] max_val,
    output logic       at_max
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear wins over increment; the count never passes max_val.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != max_val)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == max_val);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one synchronous-read RAM, with fetch anti-starvation.
// Optional access statistics are built when MEM_ARB_STATS_EN is defined.
//
// state     | meaning
// RESP_NONE | no read issued last cycle (idle, store, or cancelled fetch)
// RESP_IF   | fetch read issued last cycle, data due to IF2
// RESP_DM   | load issued last cycle, data due to MEM
module mem_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cancel,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_wen,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       stat_if_stall,
    output logic [31:0]       stat_dm_gnt
);

    localparam logic [3:0] STARVE_MAX_L = 4'(STARVE_MAX);

    resp_owner_e       state_q;
    resp_owner_e       state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_q;
    logic [31:0]       wdata_d;

    logic at_max;
    logic force_if;
    logic starve_inc;
    logic starve_clr;

    // Only the word-address field reaches the RAM; the rest aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    arb_starve_cnt u_starve (
        .clk     (clk),
        .resetn  (resetn),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .max_val (STARVE_MAX_L),
        .at_max  (at_max)
    );

    // A cancelled forced-IF cycle falls back to DM rather than going idle.
    always_comb begin
        force_if = at_max & if_req;
        if_gnt   = resetn & if_req & ~cancel & (force_if | ~dm_req);
        dm_gnt   = resetn & dm_req & ~(force_if & ~cancel);

        starve_inc = if_req & ~if_gnt;
        starve_clr = if_gnt | ~if_req | cancel;
    end

    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ram_en    = 1'b0;
        ram_wen   = 4'd0;
        if (if_gnt) begin
            ram_en = 1'b1;
            addr_d = if_addr[ADDR_W+1:2];
        end else if (dm_gnt) begin
            ram_en  = 1'b1;
            ram_wen = dm_wen;
            addr_d  = dm_addr[ADDR_W+1:2];
            wdata_d = dm_wdata;
        end
        ram_addr  = addr_d;
        ram_wdata = wdata_d;
    end

    always_comb begin
        state_d = RESP_NONE;
        if (if_gnt) begin
            state_d = RESP_IF;
        end else if (dm_gnt && (dm_wen == 4'd0)) begin
            state_d = RESP_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RESP_NONE;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Read data is forwarded unregistered; each requester captures it on its rvalid.
    always_comb begin
        if_rvalid = resetn & (state_q == RESP_IF) & ~cancel;
        dm_rvalid = resetn & (state_q == RESP_DM);
        if_rdata  = ram_rdata;
        dm_rdata  = ram_rdata;
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_stall_q;
    logic [31:0] if_stall_d;
    logic [31:0] dm_gnt_cnt_q;
    logic [31:0] dm_gnt_cnt_d;

    always_comb begin
        if_stall_d   = if_stall_q + {31'd0, (if_req & ~if_gnt)};
        dm_gnt_cnt_d = dm_gnt_cnt_q + {31'd0, dm_gnt};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            if_stall_q   <= 32'd0;
            dm_gnt_cnt_q <= 32'd0;
        end else begin
            if_stall_q   <= if_stall_d;
            dm_gnt_cnt_q <= dm_gnt_cnt_d;
        end
    end

    assign stat_if_stall = if_stall_q;
    assign stat_dm_gnt   = dm_gnt_cnt_q;
`else
    assign stat_if_stall = 32'd0;
    assign stat_dm_gnt   = 32'd0;
`endif

endmodule
